// File: rtl/branch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : branch_ctrl
// Brief    : Branch-side control for the PC unit: compare flag, loadable target
//            LUT, taken-branch counter and self-loop halt detection.
// Revision : 1.0
//------------------------------------------------------------------------------
module branch_ctrl #(
   parameter int TW    = 11,
   parameter int IDX_W = 4,
   parameter int CNT_W = 8
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Start,
   input  logic [TW-1:0]    ProgCtr,
   input  logic             IsCmp,
   input  logic             CmpResult,
   input  logic             IsBranch,
   input  logic             BranchSense,
   input  logic [IDX_W-1:0] LutIdx,
   input  logic             LutWrValid,
   input  logic [IDX_W-1:0] LutWrIdx,
   input  logic [TW-1:0]    LutWrData,
   input  logic             LoadDone,
   output logic             LutWrReady,
   output logic             BranchEn,
   output logic             BranchOnFlag,
   output logic             branch_flag,
   output logic [TW-1:0]    Target,
   output logic             Done,
   output logic [CNT_W-1:0] TakenCount
);

   localparam int c_DEPTH = 2 ** IDX_W;

   typedef enum logic [1:0] {
      S_LOAD = 2'd0,
      S_RUN  = 2'd1,
      S_HALT = 2'd2
   } state_t;

   state_t           r_state;
   logic [TW-1:0]    r_lut [c_DEPTH];
   logic             r_flag;
   logic             r_done;
   logic [CNT_W-1:0] r_cnt;

   logic             w_run;
   logic             w_taken;
   logic             w_self_loop;
   logic [TW-1:0]    w_target;

   assign w_run       = (r_state == S_RUN);
   assign w_target    = r_lut[LutIdx];
   // Taken is judged against the flag as it stood before this edge.
   assign w_taken     = w_run && IsBranch && (r_flag == BranchSense);
   assign w_self_loop = w_taken && (w_target == ProgCtr);

   assign LutWrReady   = (r_state == S_LOAD);
   assign BranchEn     = w_run && IsBranch;
   assign BranchOnFlag = BranchSense;
   assign Target       = w_target;
   assign branch_flag  = r_flag;
   assign Done         = r_done;
   assign TakenCount   = r_cnt;

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         r_state <= S_LOAD;
         r_flag  <= 1'b0;
         r_done  <= 1'b0;
         r_cnt   <= '0;
         for (int i = 0; i < c_DEPTH; i++) begin
            r_lut[i] <= '0;
         end
      end else begin
         case (r_state)
            S_LOAD: begin
               if (LutWrValid) begin
                  r_lut[LutWrIdx] <= LutWrData;
               end
               if (LoadDone) begin
                  r_state <= S_RUN;
               end
            end
            S_RUN: begin
               if (IsCmp) begin
                  r_flag <= CmpResult;
               end
               if (w_taken && (r_cnt != {CNT_W{1'b1}})) begin
                  r_cnt <= r_cnt + 1'b1;
               end
               if (w_self_loop) begin
                  r_state <= S_HALT;
                  r_done  <= 1'b1;
               end
            end
            S_HALT: begin
               if (Start) begin
                  r_state <= S_RUN;
                  r_done  <= 1'b0;
                  r_cnt   <= '0;
               end
            end
            default: begin
               r_state <= S_LOAD;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module   : tb_branch_ctrl
// Brief    : Self-checking bench for branch_ctrl (vector table + scoreboard).
// Revision : 1.0
//------------------------------------------------------------------------------
module tb_branch_ctrl;

   logic        Clk = 1'b0;
   logic        Reset, Start, IsCmp, CmpResult, IsBranch, BranchSense;
   logic        LutWrValid, LoadDone;
   logic [10:0] ProgCtr, LutWrData;
   logic [3:0]  LutIdx, LutWrIdx;
   logic        LutWrReady, BranchEn, BranchOnFlag, branch_flag, Done;
   logic [10:0] Target;
   logic [7:0]  TakenCount;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 Clk = ~Clk;

   branch_ctrl #(.TW(11), .IDX_W(4), .CNT_W(8)) dut (
      .Clk(Clk), .Reset(Reset), .Start(Start), .ProgCtr(ProgCtr),
      .IsCmp(IsCmp), .CmpResult(CmpResult), .IsBranch(IsBranch),
      .BranchSense(BranchSense), .LutIdx(LutIdx), .LutWrValid(LutWrValid),
      .LutWrIdx(LutWrIdx), .LutWrData(LutWrData), .LoadDone(LoadDone),
      .LutWrReady(LutWrReady), .BranchEn(BranchEn), .BranchOnFlag(BranchOnFlag),
      .branch_flag(branch_flag), .Target(Target), .Done(Done),
      .TakenCount(TakenCount)
   );

   typedef struct {
      logic        cmp, cres, br, sense;
      logic [3:0]  idx;
      logic        exp_en;
      logic [10:0] exp_tgt;
      logic        exp_flag;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t vt [10];
   vec_t sb [$];

   function automatic vec_t mk(input logic cmp, input logic cres, input logic br,
                               input logic sense, input logic [3:0] idx,
                               input logic en, input logic [10:0] tgt,
                               input logic flag, input logic [7:0] cnt);
      vec_t v;
      v.cmp = cmp; v.cres = cres; v.br = br; v.sense = sense; v.idx = idx;
      v.exp_en = en; v.exp_tgt = tgt; v.exp_flag = flag; v.exp_cnt = cnt;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   task automatic idle();
      Start = 1'b0; IsCmp = 1'b0; CmpResult = 1'b0; IsBranch = 1'b0;
      BranchSense = 1'b0; LutWrValid = 1'b0; LoadDone = 1'b0;
      LutWrIdx = 4'd0; LutWrData = 11'd0; ProgCtr = 11'd0;
   endtask

   task automatic lut_write(input logic [3:0] idx, input logic [10:0] data, input logic done);
      LutWrValid = 1'b1; LutWrIdx = idx; LutWrData = data; LoadDone = done;
      tick();
      LutWrValid = 1'b0; LoadDone = 1'b0;
   endtask

   initial begin
      vec_t v;
      idle();
      LutIdx = 4'd0;
      Reset  = 1'b0;
      tick(); tick();
      Reset = 1'b1;

      // Reset in LOAD while writes are in flight
      lut_write(4'd3, 11'h123, 1'b0);
      LutIdx = 4'd3; #1;
      chk("load_write_visible", Target, 11'h123);
      LutWrValid = 1'b1; LutWrIdx = 4'd4; LutWrData = 11'h055; Reset = 1'b0;
      tick();
      Reset = 1'b1; LutWrValid = 1'b0;
      chk("rst_lut3", Target, 11'h000);
      chk("rst_flag", branch_flag, 1'b0);
      chk("rst_done", Done, 1'b0);
      chk("rst_ready", LutWrReady, 1'b1);
      chk("rst_cnt", TakenCount, 8'd0);

      // Load phase: last write wins, LoadDone cycle write still lands
      IsBranch = 1'b1; #1;
      chk("load_no_branch", BranchEn, 1'b0);
      IsBranch = 1'b0;
      lut_write(4'd2, 11'h111, 1'b0);
      lut_write(4'd2, 11'h040, 1'b0);
      lut_write(4'd1, 11'h010, 1'b0);
      lut_write(4'd5, 11'h7FF, 1'b1);
      chk("run_ready", LutWrReady, 1'b0);
      LutIdx = 4'd5; #1;
      chk("lut5", Target, 11'h7FF);
      lut_write(4'd2, 11'h000, 1'b0);
      LutIdx = 4'd2; #1;
      chk("run_write_ignored", Target, 11'h040);

      // Table: flag 0, count 0 on entry
      vt[0] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 11'h040, 1'b0, 8'd0);
      vt[1] = mk(1'b0, 1'b0, 1'b0, 1'b0, 4'd5, 1'b0, 11'h7FF, 1'b0, 8'd0);
      vt[2] = mk(1'b1, 1'b1, 1'b0, 1'b0, 4'd2, 1'b0, 11'h040, 1'b1, 8'd0);
      vt[3] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 11'h040, 1'b1, 8'd1);
      vt[4] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 1'b1, 11'h7FF, 1'b1, 8'd1);
      vt[5] = mk(1'b1, 1'b0, 1'b0, 1'b0, 4'd2, 1'b0, 11'h040, 1'b0, 8'd1);
      vt[6] = mk(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 1'b1, 11'h040, 1'b1, 8'd1);
      vt[7] = mk(1'b0, 1'b0, 1'b1, 1'b1, 4'd5, 1'b1, 11'h7FF, 1'b1, 8'd2);
      vt[8] = mk(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 1'b1, 11'h040, 1'b0, 8'd3);
      vt[9] = mk(1'b0, 1'b0, 1'b1, 1'b0, 4'd2, 1'b1, 11'h040, 1'b0, 8'd4);

      for (int i = 0; i < 10; i++) begin
         IsCmp = vt[i].cmp; CmpResult = vt[i].cres; IsBranch = vt[i].br;
         BranchSense = vt[i].sense; LutIdx = vt[i].idx;
         sb.push_back(vt[i]);
         #1;
         chk($sformatf("v%0d_en", i), BranchEn, vt[i].exp_en);
         chk($sformatf("v%0d_tgt", i), Target, vt[i].exp_tgt);
         chk($sformatf("v%0d_bof", i), BranchOnFlag, vt[i].sense);
         tick();
         v = sb.pop_front();
         chk($sformatf("v%0d_flag", i), branch_flag, v.exp_flag);
         chk($sformatf("v%0d_cnt", i), TakenCount, v.exp_cnt);
         chk($sformatf("v%0d_done", i), Done, 1'b0);
      end
      idle();

      // Self-loop halt: flag 0, sense 0, target 010 == PC
      LutIdx = 4'd1; ProgCtr = 11'h010; IsBranch = 1'b1; BranchSense = 1'b0;
      #1;
      chk("halt_br_en", BranchEn, 1'b1);
      tick();
      chk("halt_done", Done, 1'b1);
      chk("halt_cnt", TakenCount, 8'd5);
      chk("halt_en_off", BranchEn, 1'b0);
      chk("halt_ready", LutWrReady, 1'b0);
      IsCmp = 1'b1; CmpResult = 1'b1;
      tick();
      chk("halt_hold_cnt", TakenCount, 8'd5);
      chk("halt_hold_flag", branch_flag, 1'b0);
      idle();
      Start = 1'b1;
      tick();
      Start = 1'b0;
      chk("resume_done", Done, 1'b0);
      chk("resume_cnt", TakenCount, 8'd0);
      LutIdx = 4'd1; #1;
      chk("resume_lut_kept", Target, 11'h010);

      // Saturation: 300 taken non-self branches
      LutIdx = 4'd2; ProgCtr = 11'h000; IsBranch = 1'b1; BranchSense = 1'b0;
      for (int i = 0; i < 300; i++) begin
         tick();
         if (i == 253 || i == 254 || i == 255 || i == 299)
            chk($sformatf("sat_%0d", i + 1), TakenCount, (i + 1 > 255) ? 255 : i + 1);
      end
      chk("sat_running", Done, 1'b0);

      // Mid-program reset
      idle();
      IsCmp = 1'b1; CmpResult = 1'b1;
      tick();
      chk("pre_rst_flag", branch_flag, 1'b1);
      idle();
      Reset = 1'b0;
      tick();
      Reset = 1'b1;
      chk("rst2_flag", branch_flag, 1'b0);
      chk("rst2_cnt", TakenCount, 8'd0);
      chk("rst2_ready", LutWrReady, 1'b1);
      chk("rst2_lut", Target, 11'h000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/branch_ctrl.md
Name: branch_ctrl

Overview:
- Drives the branch-side inputs of the program-counter unit: BranchEn, BranchOnFlag, branch_flag and Target.
- Holds the compare flag register and a loadable branch-target lookup table (LUT) indexed by the instruction's target field.
- Detects program completion, defined as a taken branch whose target equals the current PC.
- Sits between the instruction decoder/ALU and the fetch unit.

Parameters:
- TW, 11, target/PC width; must match the fetch unit's ProgCtr width.
- IDX_W, 4, LUT index width; LUT depth is 2**IDX_W.
- CNT_W, 8, width of the taken-branch counter.

Ports:
- Clk  in  1  system clock; all state changes on posedge only.
- Reset  in  1  synchronous, active-low reset.
- Start  in  1  resume request while in HALT.
- ProgCtr  in  TW  current PC from the fetch unit.
- IsCmp  in  1  compare instruction executing this cycle.
- CmpResult  in  1  ALU compare outcome.
- IsBranch  in  1  branch instruction executing this cycle.
- BranchSense  in  1  branch taken when the flag equals this value.
- LutIdx  in  IDX_W  target-field index from the instruction.
- LutWrValid  in  1  LUT load request.
- LutWrIdx  in  IDX_W  LUT load address.
- LutWrData  in  TW  LUT load data.
- LoadDone  in  1  ends the LUT load phase.
- LutWrReady  out  1  LUT accepts writes.
- BranchEn  out  1  to fetch unit.
- BranchOnFlag  out  1  to fetch unit.
- branch_flag  out  1  registered compare flag, to fetch unit.
- Target  out  TW  to fetch unit.
- Done  out  1  program halted.
- TakenCount  out  CNT_W  count of taken branches, saturating.

Behaviour:
- States: LOAD, RUN, HALT. Encoding is free.
- Reset low at a posedge, in any state, mid-load or mid-program:
  - state goes to LOAD;
  - all LUT entries go to 0;
  - branch_flag = 0, TakenCount = 0, Done = 0.
- LOAD:
  - LutWrReady = 1.
  - A write happens when LutWrValid = 1 at a posedge: LUT[LutWrIdx] <= LutWrData.
  - Repeated writes to the same index: the last one wins.
  - LoadDone = 1 moves the state to RUN at the next edge. A write presented in that same cycle is still performed.
  - BranchEn = 0; IsCmp and IsBranch are ignored.
- RUN:
  - LutWrReady = 0; LutWrValid is ignored.
  - BranchEn = IsBranch (combinational).
  - BranchOnFlag = BranchSense.
  - Target = LUT[LutIdx] (combinational read). Target is valid whenever LutIdx is stable, independent of IsBranch.
  - IsCmp = 1 at a posedge: branch_flag <= CmpResult. The flag holds otherwise.
  - Taken = IsBranch && (branch_flag == BranchSense), using the pre-edge flag value.
    - If IsCmp and IsBranch are both high in the same cycle, the branch uses the old flag; the new flag is visible next cycle.
  - Each posedge with Taken = 1 increments TakenCount, which saturates at 2**CNT_W-1 (no wrap).
  - Taken with Target == ProgCtr (self-loop): state goes to HALT and Done <= 1 at that edge. This branch is counted.
- HALT:
  - Done = 1, BranchEn = 0, LutWrReady = 0.
  - branch_flag and TakenCount hold.
  - Start = 1 at a posedge moves to RUN and clears Done and TakenCount. LUT contents and branch_flag are kept.
- Outside RUN, BranchEn is forced to 0. The fetch unit therefore never jumps while loading or halted.
- Latency:
  - Branch outputs are zero-latency combinational from inputs and registered state.
  - Flag, counter and Done take effect one edge after their cause.

Test Plan:
1. Reset low during LOAD with writes in progress -> after one edge, LUT[3] reads 0, branch_flag=0, Done=0, LutWrReady=1.
2. Load LUT[2]=11'h040 and LUT[5]=11'h7FF, then pulse LoadDone -> in RUN with LutIdx=2, Target=11'h040; LutIdx=5 gives 11'h7FF; a LutWrValid write to LUT[2]=0 in RUN leaves it at 11'h040.
3. IsCmp=1, CmpResult=1, then the next cycle IsBranch=1, BranchSense=1 -> BranchEn=1, branch_flag=1, TakenCount increments to 1. Same with BranchSense=0 -> not taken, count unchanged.
4. IsCmp=1, CmpResult=1 and IsBranch=1, BranchSense=1 in the same cycle, with the flag previously 0 -> not counted as taken; branch_flag reads 1 afterwards.
5. Taken branch with LUT[LutIdx]=11'h010 and ProgCtr=11'h010 -> Done=1 next edge, BranchEn=0 thereafter. Assert Start -> RUN, Done=0, TakenCount=0.
6. 300 consecutive taken branches (non-self targets) -> TakenCount stops at 255.
